// File: rtl/mem_tester_pkg.sv
// Shared types and constants for the PSRAM self-test block.
package mem_tester_pkg;

    // Test sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Data pattern selectors, sampled when a start is accepted.
    localparam logic [1:0] MODE_ADDR  = 2'd0;  // address as data
    localparam logic [1:0] MODE_INV   = 2'd1;  // inverted address
    localparam logic [1:0] MODE_CHECK = 2'd2;  // checkerboard keyed on a[0]
    localparam logic [1:0] MODE_WALK  = 2'd3;  // walking one, position a mod DW

endpackage

// File: rtl/mem_pattern_gen.sv
// Combinational expected-data generator. One instance feeds both the
// write data and the read compare, so the two can never disagree.
module mem_pattern_gen
    import mem_tester_pkg::*;
#(
    parameter int AW = 23,
    parameter int DW = 16
) (
    input  logic [1:0]    mode,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] data
);

    // Wide enough to zero-extend the address to DW and to form a mod DW.
    localparam int EW0 = (AW > DW) ? AW : DW;
    localparam int EW  = (EW0 > 32) ? EW0 : 32;

    localparam logic [DW-1:0] CHK_ODD  = DW'({DW/2{2'b01}});
    localparam logic [DW-1:0] CHK_EVEN = DW'({DW/2{2'b10}});

    logic [EW-1:0] a_ext;
    logic [EW-1:0] walk_pos;

    assign a_ext    = EW'(addr);
    assign walk_pos = a_ext % EW'(DW);

    // Select the pattern for the given address.
    always_comb begin
        data = '0;
        case (mode)
            MODE_ADDR:  data = a_ext[DW-1:0];
            MODE_INV:   data = ~a_ext[DW-1:0];
            MODE_CHECK: data = addr[0] ? CHK_ODD : CHK_EVEN;
            MODE_WALK:  data = DW'(1) << walk_pos;
            default:    data = '0;
        endcase
    end

endmodule

// File: rtl/mem_tester.sv
// PSRAM built-in self test: one write pass then one read/compare pass over
// [FIRST_ADDR, LAST_ADDR] through the ram_controller access handshake.
module mem_tester
    import mem_tester_pkg::*;
#(
    parameter int            AW         = 23,
    parameter int            DW         = 16,
    parameter int            ERR_W      = 16,
    parameter logic [AW-1:0] FIRST_ADDR = '0,
    parameter logic [AW-1:0] LAST_ADDR  = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       mode,
    input  logic             initialized,
    output logic             mem,
    output logic             rw,
    output logic [AW-1:0]    address,
    output logic [DW-1:0]    data_wr,
    input  logic             ready,
    input  logic [DW-1:0]    data_rd,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [AW-1:0]    first_err_addr,
    output logic [DW-1:0]    first_err_data
);

    state_t           state, state_nx;
    logic [1:0]       mode_q, mode_nx;
    logic             mem_nx, rw_nx, busy_nx, done_nx, pass_nx;
    logic [AW-1:0]    addr_nx;
    logic [DW-1:0]    data_nx;
    logic [ERR_W-1:0] err_nx;
    logic             fev_nx;
    logic [AW-1:0]    fea_nx;
    logic [DW-1:0]    fed_nx;

    logic             accept;
    logic             at_last;
    logic [1:0]       gen_mode;
    logic [AW-1:0]    gen_addr;
    logic [DW-1:0]    gen_data;

    assign accept  = ((state == ST_IDLE) || (state == ST_DONE)) && start && initialized;
    assign at_last = (address == LAST_ADDR);

    // The generator always looks at the address about to be loaded, so the
    // registered data_wr equals pattern(mode_q, address) in every cycle of a
    // run and doubles as the read-compare reference. At LAST_ADDR the next
    // address is FIRST_ADDR, which also keeps the counter from wrapping.
    assign gen_mode = accept ? mode : mode_q;
    assign gen_addr = (accept || at_last) ? FIRST_ADDR : address + AW'(1);

    mem_pattern_gen #(
        .AW (AW),
        .DW (DW)
    ) u_pat (
        .mode (gen_mode),
        .addr (gen_addr),
        .data (gen_data)
    );

    // Next-state and next-output decode; abort outranks ready.
    always_comb begin
        state_nx = state;
        mode_nx  = mode_q;
        mem_nx   = mem;
        rw_nx    = rw;
        addr_nx  = address;
        data_nx  = data_wr;
        busy_nx  = busy;
        done_nx  = done;
        pass_nx  = pass;
        err_nx   = err_count;
        fev_nx   = first_err_valid;
        fea_nx   = first_err_addr;
        fed_nx   = first_err_data;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_nx = ST_WRITE;
                    mode_nx  = mode;
                    err_nx   = '0;
                    fev_nx   = 1'b0;
                    fea_nx   = '0;
                    fed_nx   = '0;
                    done_nx  = 1'b0;
                    pass_nx  = 1'b0;
                    addr_nx  = FIRST_ADDR;
                    data_nx  = gen_data;
                    rw_nx    = 1'b0;
                    mem_nx   = 1'b1;
                    busy_nx  = 1'b1;
                end
            end
            ST_WRITE, ST_READ: begin
                if (abort) begin
                    state_nx = ST_IDLE;
                    mem_nx   = 1'b0;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b0;
                    pass_nx  = 1'b0;
                end else if (ready) begin
                    if (state == ST_READ && data_rd != data_wr) begin
                        err_nx = (err_count == '1) ? err_count : err_count + ERR_W'(1);
                        if (!first_err_valid) begin
                            fev_nx = 1'b1;
                            fea_nx = address;
                            fed_nx = data_rd;
                        end
                    end
                    if (!at_last) begin
                        addr_nx = address + AW'(1);
                        data_nx = gen_data;
                    end else if (state == ST_WRITE) begin
                        state_nx = ST_READ;
                        addr_nx  = FIRST_ADDR;
                        data_nx  = gen_data;
                        rw_nx    = 1'b1;
                    end else begin
                        // Final read: its compare is already folded into err_nx.
                        state_nx = ST_DONE;
                        mem_nx   = 1'b0;
                        rw_nx    = 1'b1;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                        pass_nx  = (err_nx == '0);
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= ST_IDLE;
            mode_q          <= MODE_ADDR;
            mem             <= 1'b0;
            rw              <= 1'b0;
            address         <= FIRST_ADDR;
            data_wr         <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
            first_err_data  <= '0;
        end else begin
            state           <= state_nx;
            mode_q          <= mode_nx;
            mem             <= mem_nx;
            rw              <= rw_nx;
            address         <= addr_nx;
            data_wr         <= data_nx;
            busy            <= busy_nx;
            done            <= done_nx;
            pass            <= pass_nx;
            err_count       <= err_nx;
            first_err_valid <= fev_nx;
            first_err_addr  <= fea_nx;
            first_err_data  <= fed_nx;
        end
    end

endmodule

// File: tb/tb_mem_tester.sv
// Scoreboard bench for mem_tester: a memory model answers accesses, expected
// writes and end-of-test results are queued at start and checked by a monitor.
module tb_mem_tester;

    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int ERR_W = 2;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic [ERR_W-1:0] err;
        logic             pass;
        logic             fev;
        logic [AW-1:0]    fea;
        logic [DW-1:0]    fed;
    } res_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // main DUT: full 16-word window
    logic             start = 1'b0, abort, initialized = 1'b1, ready;
    logic [1:0]       mode = 2'd0;
    logic [DW-1:0]    data_rd;
    logic             mem, rw, busy, done, pass, fev;
    logic [AW-1:0]    address, fea;
    logic [DW-1:0]    data_wr, fed;
    logic [ERR_W-1:0] err_count;

    // single-address DUT
    logic             s_start = 1'b0, s_ready = 1'b0;
    logic [DW-1:0]    s_data_rd = '0;
    logic             s_mem, s_rw, s_busy, s_done, s_pass, s_fev;
    logic [AW-1:0]    s_address, s_fea;
    logic [DW-1:0]    s_data_wr, s_fed;
    logic [3:0]       s_err;

    mem_tester #(.AW(AW), .DW(DW), .ERR_W(ERR_W), .FIRST_ADDR(4'h0), .LAST_ADDR(4'hF)) u_dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
        .initialized(initialized), .mem(mem), .rw(rw), .address(address),
        .data_wr(data_wr), .ready(ready), .data_rd(data_rd), .busy(busy),
        .done(done), .pass(pass), .err_count(err_count), .first_err_valid(fev),
        .first_err_addr(fea), .first_err_data(fed)
    );

    mem_tester #(.AW(AW), .DW(DW), .ERR_W(4), .FIRST_ADDR(4'h7), .LAST_ADDR(4'h7)) u_one (
        .clk(clk), .reset(reset), .start(s_start), .abort(1'b0), .mode(2'd0),
        .initialized(1'b1), .mem(s_mem), .rw(s_rw), .address(s_address),
        .data_wr(s_data_wr), .ready(s_ready), .data_rd(s_data_rd), .busy(s_busy),
        .done(s_done), .pass(s_pass), .err_count(s_err), .first_err_valid(s_fev),
        .first_err_addr(s_fea), .first_err_data(s_fed)
    );

    int   n_pass = 0;
    int   n_total = 0;
    wr_t  wq[$];
    res_t rq[$];
    int   fault = 0;     // 0 none, 1 bit10 stuck-0 @0xA, 2 flip bit0 @0xF, 3 all 0xFFFF
    int   abort_at = 0;  // read number (1-based) that gets abort with its ready

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] exp_pat(input logic [1:0] m, input logic [AW-1:0] a);
        case (m)
            2'd0:    return {12'h000, a};
            2'd1:    return ~{12'h000, a};
            2'd2:    return a[0] ? 16'h5555 : 16'hAAAA;
            default: return 16'h0001 << a;
        endcase
    endfunction

    function automatic logic [DW-1:0] corrupt(input logic [AW-1:0] a, input logic [DW-1:0] d);
        case (fault)
            1:       return (a == 4'hA) ? (d & ~16'h0400) : d;
            2:       return (a == 4'hF) ? (d ^ 16'h0001) : d;
            3:       return 16'hFFFF;
            default: return d;
        endcase
    endfunction

    // memory model: two-cycle ready latency, driven on the falling edge
    initial begin
        logic [DW-1:0] arr [16];
        int acc = 0;
        int rd_cnt = 0;
        ready = 1'b0; abort = 1'b0; data_rd = '0;
        forever begin
            @(negedge clk);
            ready = 1'b0;
            abort = 1'b0;
            if (!busy) rd_cnt = 0;
            if (reset && mem) begin
                acc++;
                if (acc == 2) begin
                    acc = 0;
                    ready = 1'b1;
                    if (!rw) arr[address] = data_wr;
                    else begin
                        rd_cnt++;
                        data_rd = corrupt(address, arr[address]);
                        if (rd_cnt == abort_at) abort = 1'b1;
                    end
                end
            end else acc = 0;
        end
    end

    // monitor: pops expected writes and results as the DUT presents them
    initial begin
        logic done_q = 1'b0;
        wr_t  w;
        res_t r;
        forever begin
            @(negedge clk); #1;
            if (reset && ready && mem && !rw && !abort) begin
                if (wq.size() == 0) check("unexpected_write", 32'(address), 32'hFFFF_FFFF);
                else begin
                    w = wq.pop_front();
                    check("wr_addr", 32'(address), 32'(w.addr));
                    check("wr_data", 32'(data_wr), 32'(w.data));
                end
            end
            if (done && !done_q) begin
                if (rq.size() == 0) check("unexpected_done", 32'(done), 32'h0);
                else begin
                    r = rq.pop_front();
                    check("err_count", 32'(err_count), 32'(r.err));
                    check("pass", 32'(pass), 32'(r.pass));
                    check("first_err_valid", 32'(fev), 32'(r.fev));
                    check("first_err_addr", 32'(fea), 32'(r.fea));
                    check("first_err_data", 32'(fed), 32'(r.fed));
                    check("mem_after_done", 32'(mem), 32'h0);
                    check("busy_after_done", 32'(busy), 32'h0);
                end
            end
            done_q = done;
        end
    end

    task automatic queue_writes(input logic [1:0] m);
        for (int a = 0; a < 16; a++) wq.push_back('{AW'(a), exp_pat(m, AW'(a))});
    endtask

    task automatic pulse_start(input logic [1:0] m);
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run(input string tag, input logic [1:0] m, input int f, input res_t exp);
        bit seen = 0;
        fault = f;
        queue_writes(m);
        rq.push_back(exp);
        pulse_start(m);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            if (done) begin seen = 1; break; end
        end
        if (!seen) check({tag, "_done_timeout"}, 32'(done), 32'h1);
        @(negedge clk); #2;
        check({tag, "_wq_drained"}, 32'(wq.size()), 32'h0);
        check({tag, "_rq_drained"}, 32'(rq.size()), 32'h0);
    endtask

    initial begin
        bit idle_seen;
        // reset values
        repeat (3) @(negedge clk);
        #1;
        check("rst_mem", 32'(mem), 0);
        check("rst_rw", 32'(rw), 0);
        check("rst_address", 32'(address), 0);
        check("rst_data_wr", 32'(data_wr), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err_count), 0);
        check("rst_fev", 32'(fev), 0);
        check("rst_one_address", 32'(s_address), 32'h7);
        @(negedge clk);
        reset = 1'b1;

        // start ignored while not initialized
        initialized = 1'b0;
        pulse_start(2'd0);
        #1;
        check("noinit_busy", 32'(busy), 0);
        check("noinit_mem", 32'(mem), 0);
        initialized = 1'b1;

        run("addr", 2'd0, 0, '{2'd0, 1'b1, 1'b0, 4'h0, 16'h0000});
        run("walk", 2'd3, 1, '{2'd1, 1'b0, 1'b1, 4'hA, 16'h0000});
        run("inv_last", 2'd1, 2, '{2'd1, 1'b0, 1'b1, 4'hF, 16'hFFF1});
        run("sat", 2'd0, 3, '{2'd3, 1'b0, 1'b1, 4'h0, 16'hFFFF});
        run("check", 2'd2, 0, '{2'd0, 1'b1, 1'b0, 4'h0, 16'h0000});

        // abort together with the 5th read's ready; a mid-run start is ignored
        fault = 0;
        abort_at = 5;
        queue_writes(2'd0);
        pulse_start(2'd0);
        repeat (6) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idle_seen = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            if (!busy) begin idle_seen = 1; break; end
        end
        check("abort_idle", 32'(idle_seen), 1);
        check("abort_mem", 32'(mem), 0);
        check("abort_done", 32'(done), 0);
        check("abort_pass", 32'(pass), 0);
        check("abort_address", 32'(address), 32'h4);
        check("abort_err", 32'(err_count), 0);
        check("abort_wq_drained", 32'(wq.size()), 0);
        abort_at = 0;

        // reset asserted mid-write
        queue_writes(2'd1);
        pulse_start(2'd1);
        repeat (8) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_mem", 32'(mem), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_rw", 32'(rw), 0);
        check("midrst_address", 32'(address), 0);
        check("midrst_data_wr", 32'(data_wr), 0);
        wq.delete();
        @(negedge clk); #2;
        reset = 1'b1;

        // single-address window: one write then one read
        @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        #1;
        check("one_wr_mem", 32'(s_mem), 1);
        check("one_wr_rw", 32'(s_rw), 0);
        check("one_wr_addr", 32'(s_address), 32'h7);
        check("one_wr_data", 32'(s_data_wr), 32'h7);
        s_ready = 1'b1;
        @(negedge clk);
        s_ready = 1'b0;
        #1;
        check("one_rd_rw", 32'(s_rw), 1);
        check("one_rd_addr", 32'(s_address), 32'h7);
        check("one_rd_busy", 32'(s_busy), 1);
        s_data_rd = 16'h0007;
        s_ready = 1'b1;
        @(negedge clk);
        s_ready = 1'b0;
        #1;
        check("one_done", 32'(s_done), 1);
        check("one_pass", 32'(s_pass), 1);
        check("one_mem", 32'(s_mem), 0);
        check("one_err", 32'(s_err), 0);
        check("one_fev", 32'(s_fev), 0);
        check("one_fea_fed", {12'h0, s_fea, s_fed}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
